dm_cache_ctrl: RTL
==================

# dm_cache_ctrl

Parametrised direct-mapped cache with a request/response front end and a line-refill / write-through back end toward main memory. It generalises the fixed 256-line × 16-word cache storage block: line count, words per line and word width are parameters, and it adds per-line valid bits cleared by reset, a miss-handling state machine, ready/valid handshakes on both sides and a flush command. It sits between the processor load/store path and the memory model.

## Interface
- `ADDR_W`, 32: word-address width. `addr = {tag, index, offset}`.
- `WORD_W`, 32: data word width.
- `WORDS`, 16: words per line, a power of 2. `OFF_W = clog2(WORDS)`.
- `LINES`, 256: number of lines, a power of 2. `IDX_W = clog2(LINES)`. `TAG_W = ADDR_W - IDX_W - OFF_W`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `WORD_W`: store data.
- `flush` in 1: invalidate all lines.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out `WORD_W`: load data.
- `resp_hit` out 1: the access hit.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: memory request handshake.
- `mem_req_we` out 1: 1 = word write, 0 = line read.
- `mem_req_addr` out `ADDR_W`: word address. Offset bits are 0 for line reads.
- `mem_req_wdata` out `WORD_W`: write-through data.
- `mem_resp_valid` in 1: refill line present.
- `mem_resp_data` in `WORDS*WORD_W`: refill line. Word k is bits `[k*WORD_W +: WORD_W]`.

## Operation
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, WT_REQ.
- IDLE:
  - `req_ready = !flush`.
  - `flush` clears every valid bit in one cycle and stays in IDLE. No `resp_valid` is produced.
  - On `req_valid && req_ready`, latch addr, write and wdata, then go to LOOKUP.
  - `flush` is ignored outside IDLE.
- LOOKUP: hit = `valid[index] && tag[index] == tag`.
  - Read hit: `resp_valid=1`, `resp_hit=1`, `resp_rdata` = word at offset. Go to IDLE.
  - Read miss: go to MISS_REQ.
  - Write hit: update that word in the line. Go to WT_REQ.
  - Write miss: no allocate, line untouched. Go to WT_REQ.
- MISS_REQ: `mem_req_valid=1`, `we=0`, `mem_req_addr = {tag, index, 0}`. Hold stable until `mem_req_ready`, then go to MISS_WAIT.
- MISS_WAIT: on `mem_resp_valid`, write the line data, tag and `valid=1`, then go to FILL.
- FILL: `resp_valid=1`, `resp_hit=0`, `resp_rdata` = word at offset from the new line. Go to IDLE.
- WT_REQ: `mem_req_valid=1`, `we=1`, full word address and wdata. Hold until `mem_req_ready`. In that same cycle assert `resp_valid`, and `resp_hit` = the hit result latched in LOOKUP. Go to IDLE.
- `resp_rdata` is don't-care for writes and must be driven 0.
- Refill replaces the line unconditionally. There is no dirty state, because memory is always current (write-through).

## Timing
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE and all valid bits go to 0.
  - `resp_valid`, `resp_hit`, `mem_req_valid` and `mem_req_we` are 0. `resp_rdata`, `mem_req_addr` and `mem_req_wdata` are 0.
  - Data and tag arrays are not reset.
- Read hit latency: accept at edge N, `resp_valid` high in cycle N+1.
- Read miss: accept at N, `mem_req_valid` from N+2. `resp_valid` comes one cycle after the edge that samples `mem_resp_valid`.
- Write: `resp_valid` comes in the cycle `mem_req_ready` is seen in WT_REQ, at minimum N+2.
- Back-to-back: `req_ready` is high again the cycle after `resp_valid`. Throughput is at most one access per 2 cycles.
- `mem_resp_valid` outside MISS_WAIT is ignored.
- Reset mid-miss abandons the memory transaction. A late `mem_resp_valid` is ignored.

## Structure
- Package `dm_cache_pkg`:
  - State enum.
  - Width-derivation functions: `clog2`, `TAG_W`.
  - Field-slice helpers for tag, index and offset.
- Sub-module `dm_cache_array`:
  - Tag, data and valid storage with registered write ports.
  - Combinational read by index.
  - Whole-line write, single-word write.
  - `valid_clr_all`, reset-cleared valid vector.
- The top level holds the FSM, the request latch and the memory-side drive.

## Test plan
Defaults throughout; `0x1234` = tag 0x1, index 0x23, offset 4.
- Reset then read `0x1234`: miss. `mem_req_addr = 0x1230`, `we=0`. Refill word4 = `0xDEADBEEF`. Then `resp_valid`, `resp_hit=0`, `rdata=0xDEADBEEF`.
- Read `0x1234` again: `resp_valid` at N+1, `resp_hit=1`, `rdata=0xDEADBEEF`. No `mem_req_valid`.
- Write `0x1238 = 0xCAFEF00D` (hit): `mem_req_we=1`, addr `0x1238`, `wdata=0xCAFEF00D`, `resp_hit=1`. Stall `mem_req_ready` 3 cycles: request stable, `resp_valid` only on ready. A following read of `0x1238` hits with `0xCAFEF00D`.
- Read `0x2234` (same index 0x23, tag 0x2): miss, refill replaces the line. A following read of `0x1234` misses.
- Write miss `0x5000`: write-through only. A following read of `0x5000` misses.
- Pulse `flush` in IDLE with `req_valid` high: `req_ready=0` that cycle, then a read of `0x2234` misses.
- Assert `rst_n=0` during MISS_WAIT: all outputs go to 0 immediately. After release, a read of `0x1234` misses.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared types and width/field helpers for the direct-mapped cache controller.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    WT_REQ
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines,
                                        input int unsigned words);
    return addr_w - clog2(lines) - clog2(words);
  endfunction

  // Field helpers work on a 64-bit zero-extended address; callers size-cast the result.
  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int unsigned off_w,
                                           input int unsigned idx_w);
    return a >> (off_w + idx_w);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] a, input int unsigned off_w,
                                             input int unsigned idx_w);
    return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_offset(input logic [63:0] a, input int unsigned off_w);
    return a & ((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/data/valid storage: combinational read by index, registered line and word writes.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned LINES  = 256,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned OFF_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_valid,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [WORDS*WORD_W-1:0]   rd_line,
  input  logic                      line_we,
  input  logic [IDX_W-1:0]          line_idx,
  input  logic [TAG_W-1:0]          line_tag,
  input  logic [WORDS*WORD_W-1:0]   line_data,
  input  logic                      word_we,
  input  logic [IDX_W-1:0]          word_idx,
  input  logic [OFF_W-1:0]          word_off,
  input  logic [WORD_W-1:0]         word_data,
  input  logic                      valid_clr_all
);

  logic [WORDS*WORD_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [LINES-1:0]        valid;

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

  // Data and tags carry no reset; only the valid vector qualifies them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[line_idx] <= line_data;
      tag_mem[line_idx]  <= line_tag;
    end else if (word_we) begin
      data_mem[word_idx][word_off*WORD_W +: WORD_W] <= word_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (valid_clr_all) begin
      valid <= '0;
    end else if (line_we) begin
      valid[line_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller with line refill.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned LINES  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [WORD_W-1:0]       req_wdata,
  input  logic                    flush,
  output logic                    resp_valid,
  output logic [WORD_W-1:0]       resp_rdata,
  output logic                    resp_hit,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [WORD_W-1:0]       mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [WORDS*WORD_W-1:0] mem_resp_data
);

  localparam int unsigned OFF_W = clog2(WORDS);
  localparam int unsigned IDX_W = clog2(LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES, WORDS);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                hit_q;

  logic [TAG_W-1:0]        tag_f;
  logic [IDX_W-1:0]        idx_f;
  logic [OFF_W-1:0]        off_f;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [WORDS*WORD_W-1:0] rd_line;
  logic [WORD_W-1:0]       rd_word;
  logic                    hit;

  assign tag_f   = TAG_W'(addr_tag(64'(addr_q), OFF_W, IDX_W));
  assign idx_f   = IDX_W'(addr_index(64'(addr_q), OFF_W, IDX_W));
  assign off_f   = OFF_W'(addr_offset(64'(addr_q), OFF_W));
  assign hit     = rd_valid && (rd_tag == tag_f);
  assign rd_word = rd_line[off_f*WORD_W +: WORD_W];

  dm_cache_array #(
    .WORD_W(WORD_W),
    .WORDS (WORDS),
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx       (idx_f),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_line      (rd_line),
    .line_we      ((state == MISS_WAIT) && mem_resp_valid),
    .line_idx     (idx_f),
    .line_tag     (tag_f),
    .line_data    (mem_resp_data),
    .word_we      ((state == LOOKUP) && write_q && hit),
    .word_idx     (idx_f),
    .word_off     (off_f),
    .word_data    (wdata_q),
    .valid_clr_all((state == IDLE) && flush)
  );

  assign req_ready = (state == IDLE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= hit;
          if (write_q)  state <= WT_REQ;
          else if (hit) state <= IDLE;
          else          state <= MISS_REQ;
        end
        MISS_REQ:  if (mem_req_ready)  state <= MISS_WAIT;
        MISS_WAIT: if (mem_resp_valid) state <= FILL;
        FILL:      state <= IDLE;
        WT_REQ:    if (mem_req_ready)  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; the write-through response tracks mem_req_ready.
  always_comb begin
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      LOOKUP: begin
        if (!write_q && hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_rdata = rd_word;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_f, idx_f, {OFF_W{1'b0}}};
      end
      FILL: begin
        resp_valid = 1'b1;
        resp_rdata = rd_word;
      end
      WT_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        resp_valid    = mem_req_ready;
        resp_hit      = mem_req_ready && hit_q;
      end
      default: ;
    endcase
  end

endmodule
